// File: rtl/avr_uart_pkg.sv
// Shared types and constants for the FPGA->AVR UART transmitter.
package avr_uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/avr_uart_tx_if.sv
// Byte-stream valid/ready handshake feeding the AVR UART transmitter.
interface avr_uart_tx_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/avr_tx_fifo.sv
// Synchronous byte FIFO; pointers carry an extra wrap bit to tell full from empty.
module avr_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/avr_uart_tx.sv
// 8N1 LSB-first UART transmitter toward the AVR, gated by the AVR's busy line.
// Define AVR_TX_FIFO_EN to replace the one-byte holding register with an avr_tx_fifo.
module avr_uart_tx
  import avr_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  avr_uart_tx_if.slave  in_if,
  input  logic          avr_rx_busy,
  output logic          avr_rx,
  output logic          tx_busy
);

  localparam int            CW      = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    BIT_MAX = 3'(DATA_BITS - 1);

  if (CLK_PER_BIT < 2 || FIFO_DEPTH < 2) begin : g_param_check
    $error("avr_uart_tx: CLK_PER_BIT and FIFO_DEPTH must both be >= 2");
  end

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_meta_q, busy_s_q;

  logic              buf_push_s, buf_pop_s, buf_full_s, buf_empty_s;
  logic [7:0]        buf_data_s;
  logic              start_ok_s, bit_end_s;

  assign buf_push_s     = in_if.in_valid && !buf_full_s;
  assign in_if.in_ready = !buf_full_s;

`ifdef AVR_TX_FIFO_EN
  avr_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push_s),
    .wdata (in_if.in_data),
    .pop   (buf_pop_s),
    .rdata (buf_data_s),
    .full  (buf_full_s),
    .empty (buf_empty_s)
  );
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;

  assign buf_data_s  = hold_q;
  assign buf_full_s  = hold_valid_q;
  assign buf_empty_s = !hold_valid_q;

  // Holding register: a push only happens while empty, a pop only while full
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (buf_push_s) begin
      hold_d       = in_if.in_data;
      hold_valid_d = 1'b1;
    end else if (buf_pop_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Holding register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

  // Two-flop synchroniser for the asynchronous AVR busy line; resets to "busy"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta_q <= 1'b1;
      busy_s_q    <= 1'b1;
    end else begin
      busy_meta_q <= avr_rx_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  assign start_ok_s = !buf_empty_s && !busy_s_q;
  assign bit_end_s  = (cnt_q == CNT_MAX);

  // Frame sequencing; busy is only consulted where a new frame could begin
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    buf_pop_s = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_ok_s) begin
          buf_pop_s = 1'b1;
          shift_d   = buf_data_s;
          tx_d      = 1'b0;
          state_d   = START;
        end else begin
          tx_d = IDLE_LEVEL;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_idx_q == BIT_MAX) begin
            tx_d    = IDLE_LEVEL;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (start_ok_s) begin
            buf_pop_s = 1'b1;
            shift_d   = buf_data_s;
            tx_d      = 1'b0;
            state_d   = START;
          end else begin
            tx_d    = IDLE_LEVEL;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        tx_d    = IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign avr_rx  = tx_q;
  assign tx_busy = (state_q != IDLE) || !buf_empty_s;

endmodule

// File: tb/tb_avr_uart_tx.sv
// Self-checking bench for avr_uart_tx: decodes the serial line and compares against accepted bytes.
module tb_avr_uart_tx;

  localparam int CPB = 4;
`ifdef AVR_TX_FIFO_EN
  localparam int EXP_CAP = 8;
`else
  localparam int EXP_CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic avr_rx_busy = 1'b0;
  logic avr_rx;
  logic tx_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];

  avr_uart_tx_if in_if ();

  avr_uart_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if       (in_if),
    .avr_rx_busy (avr_rx_busy),
    .avr_rx      (avr_rx),
    .tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] b, input int max_wait);
    int w = 0;
    in_if.in_data  = b;
    in_if.in_valid = 1'b1;
    while (!in_if.in_ready && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    if (!in_if.in_ready) begin
      check_eq("push_timeout", 32'(in_if.in_ready), 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
    end
    in_if.in_valid = 1'b0;
  endtask

  // Waits up to 'timeout' negedges for a start bit, then samples and decodes a whole frame.
  task automatic expect_frame(input int timeout);
    logic       smp [10*CPB];
    logic [7:0] got, exp_b;
    logic [7:0] unstable;
    int         w, zeros, ones;
    @(negedge clk);
    w = 1;
    while (avr_rx !== 1'b0 && w < timeout) begin
      @(negedge clk);
      w++;
    end
    if (avr_rx !== 1'b0) begin
      check_eq("start_timeout", 32'(avr_rx), 32'd0);
      return;
    end
    smp[0] = avr_rx;
    for (int i = 1; i < 10*CPB; i++) begin
      @(negedge clk);
      smp[i] = avr_rx;
    end
    zeros = 0;
    ones  = 0;
    unstable = 8'h00;
    for (int i = 0; i < CPB; i++) begin
      if (smp[i] === 1'b0) zeros++;
      if (smp[9*CPB + i] === 1'b1) ones++;
    end
    for (int b = 0; b < 8; b++) begin
      got[b] = smp[(b+1)*CPB];
      for (int k = 1; k < CPB; k++) begin
        if (smp[(b+1)*CPB + k] !== got[b]) unstable[b] = 1'b1;
      end
    end
    check_eq("start_bit_len", 32'(zeros), 32'(CPB));
    check_eq("data_bit_stable", 32'(unstable), 32'd0);
    check_eq("stop_bit_len", 32'(ones), 32'(CPB));
    if (exp_q.size() == 0) begin
      check_eq("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
    end else begin
      exp_b = exp_q.pop_front();
      check_eq("frame_byte", 32'(got), 32'(exp_b));
    end
  endtask

  // Line must stay idle-high with tx_busy asserted for n cycles.
  task automatic expect_held(input string tag, input int n);
    int hi = 0;
    int bz = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (avr_rx === 1'b1) hi++;
      if (tx_busy === 1'b1) bz++;
    end
    check_eq({tag, "_line_high"}, 32'(hi), 32'(n));
    check_eq({tag, "_tx_busy"}, 32'(bz), 32'(n));
  endtask

  initial begin
    int acc;
    logic [7:0] rb;
    in_if.in_data  = 8'h00;
    in_if.in_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_avr_rx", 32'(avr_rx), 32'd1);
    check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_if.in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single frame, start bit on the edge after accept
    push(8'hA5, 4);
    check_eq("t1_pre_start", 32'(avr_rx), 32'd1);
    expect_frame(1);
    @(negedge clk);
    check_eq("t1_idle_after", 32'(tx_busy), 32'd0);

    // 2: AVR busy holds the frame off until busy clears
    avr_rx_busy = 1'b1;
    repeat (3) @(negedge clk);
    push(8'h3C, 4);
    expect_held("t2", 20);
    avr_rx_busy = 1'b0;
    expect_frame(3);

    // 3: busy raised mid-frame neither truncates nor stretches it
    fork
      begin
        expect_frame(4);
        expect_held("t3", 20);
      end
      begin
        push(8'h81, 4);
        push(8'h42, 8);
        repeat (6) @(negedge clk);
        avr_rx_busy = 1'b1;
      end
    join
    avr_rx_busy = 1'b0;
    expect_frame(3);
    check_eq("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // 4: continuous frames with no idle gap
    repeat (2) @(negedge clk);
    fork
      begin
        expect_frame(4);
        expect_frame(1);
      end
      begin
        push(8'h00, 10);
        push(8'hFF, 60);
      end
    join

    // 5: buffer capacity while busy, then ordered drain
    repeat (2) @(negedge clk);
    avr_rx_busy = 1'b1;
    repeat (3) @(negedge clk);
    acc = 0;
    for (int k = 0; k < EXP_CAP + 3; k++) begin
      if (in_if.in_ready) begin
        rb = 8'($urandom);
        push(rb, 0);
        acc++;
      end
    end
    check_eq("t5_accepted", 32'(acc), 32'(EXP_CAP));
    check_eq("t5_ready_low", 32'(in_if.in_ready), 32'd0);
    avr_rx_busy = 1'b0;
    expect_frame(3);
    for (int k = 1; k < acc; k++) expect_frame(1);

    // Randomized bytes with random gaps
    repeat (2) @(negedge clk);
    fork
      begin
        for (int k = 0; k < 6; k++) expect_frame(80);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push(8'($urandom), 100);
        end
      end
    join
    check_eq("rand_queue_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset mid-frame aborts immediately and discards pending bytes
    repeat (2) @(negedge clk);
    push(8'h00, 4);
    push(8'($urandom), 8);
    repeat (10) @(negedge clk);
    check_eq("t6_pre_reset_low", 32'(avr_rx), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_avr_rx", 32'(avr_rx), 32'd1);
    check_eq("t6_rst_tx_busy", 32'(tx_busy), 32'd0);
    check_eq("t6_rst_in_ready", 32'(in_if.in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t6_idle_after_reset", 32'(tx_busy), 32'd0);
    push(8'h55, 4);
    expect_frame(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
